// File: rtl/fmps_write_link.sv
// FMPS Aurora transmit link: queues per-FMPS status words and serialises each
// as a two-beat AXI-Stream packet. Optional header sequence number: FMPS_WRITE_LINK_SEQ_EN.
module fmps_write_link #(
  parameter int          INDEX_WIDTH  = 5,
  parameter int          FIFO_AW      = 4,
  parameter logic [15:0] HEADER_MAGIC = 16'hB6CF
) (
  input  logic                          auroraClk,
  input  logic                          auroraReset,
  input  logic                          auroraChannelUp,
  input  logic                          FAstrobe,
  input  logic                          fmpsStrobe,
  input  logic [INDEX_WIDTH-1:0]        fmpsIndex,
  input  logic [31:0]                   fmpsData,
  output logic [31:0]                   TDATA,
  output logic                          TVALID,
  output logic                          TLAST,
  input  logic                          TREADY,
  output logic [(1<<INDEX_WIDTH)-1:0]   sentBitmap,
  output logic [INDEX_WIDTH:0]          sentCounter,
  output logic [15:0]                   dupDropCount,
  output logic [15:0]                   ovfDropCount,
  output logic                          busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int NBITS = 1 << INDEX_WIDTH;
  localparam int EW    = INDEX_WIDTH + 32;
  localparam logic [INDEX_WIDTH:0] CNT_MAX = {1'b1, {INDEX_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, HDR, DAT} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [31:0]            cur_data_q, cur_data_d;
  logic [FIFO_AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NBITS-1:0]       bitmap_q, bitmap_d, bitmap_eff;
  logic [INDEX_WIDTH:0]   sent_cnt_q, sent_cnt_d;
  logic [15:0]            dup_q, dup_d, ovf_q, ovf_d;
`ifdef FMPS_WRITE_LINK_SEQ_EN
  logic [9:0]             seq_q, seq_d;
`endif

  logic [EW-1:0]          mem_q [DEPTH];
  logic [FIFO_AW:0]       count;
  logic                   empty, full, pop, wr_en, dup_drop, ovf_drop;
  logic [EW-1:0]          head;
  logic [16:0]            ovf_sum;

  function automatic logic [31:0] make_header(input logic [INDEX_WIDTH-1:0] idx,
                                              input logic [9:0] seq);
    return {HEADER_MAGIC, 16'h0000} | (32'(idx) << 10) | 32'(seq);
  endfunction

  assign count      = wr_ptr_q - rd_ptr_q;
  assign empty      = (count == '0);
  assign full       = (count == (FIFO_AW+1)'(DEPTH));
  assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  // A same-cycle FA strobe opens the new cycle before the duplicate check.
  assign bitmap_eff = FAstrobe ? '0 : bitmap_q;

  // Transmit sequencing and FIFO read side.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    cur_data_d = cur_data_q;
    rd_ptr_d   = rd_ptr_q;
    sent_cnt_d = FAstrobe ? '0 : sent_cnt_q;
    pop        = 1'b0;
`ifdef FMPS_WRITE_LINK_SEQ_EN
    seq_d      = seq_q;
`endif
    if (!auroraChannelUp) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      rd_ptr_d = wr_ptr_q;
`ifdef FMPS_WRITE_LINK_SEQ_EN
      seq_d    = 10'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: pop = !empty;
        HDR: if (TREADY) begin
          tdata_d = cur_data_q;
          tlast_d = 1'b1;
          state_d = DAT;
        end
        DAT: if (TREADY) begin
          pop = !empty;
          if (!FAstrobe && sent_cnt_q != CNT_MAX)
            sent_cnt_d = sent_cnt_q + (INDEX_WIDTH+1)'(1);
`ifdef FMPS_WRITE_LINK_SEQ_EN
          seq_d = seq_q + 10'd1;
`endif
          if (empty) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + (FIFO_AW+1)'(1);
        cur_data_d = head[31:0];
`ifdef FMPS_WRITE_LINK_SEQ_EN
        tdata_d    = make_header(head[EW-1:32], seq_d);
`else
        tdata_d    = make_header(head[EW-1:32], 10'd0);
`endif
        tvalid_d   = 1'b1;
        tlast_d    = 1'b0;
        state_d    = HDR;
      end
    end
  end

  // Submission filtering, FIFO write side and drop accounting.
  always_comb begin
    dup_drop = 1'b0;
    ovf_drop = 1'b0;
    wr_en    = 1'b0;
    bitmap_d = bitmap_eff;
    if (fmpsStrobe) begin
      if (!auroraChannelUp)             ovf_drop = 1'b1;
      else if (bitmap_eff[fmpsIndex])   dup_drop = 1'b1;
      else if (full && !pop)            ovf_drop = 1'b1;
      else begin
        wr_en               = 1'b1;
        bitmap_d[fmpsIndex] = 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(wr_en);
    dup_d    = (dup_drop && dup_q != 16'hFFFF) ? dup_q + 16'd1 : dup_q;
    // A channel-down flush charges every discarded entry in one edge.
    ovf_sum  = {1'b0, ovf_q} + 17'(ovf_drop) + (auroraChannelUp ? 17'd0 : 17'(count));
    ovf_d    = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  always_ff @(posedge auroraClk or posedge auroraReset) begin
    if (auroraReset) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      cur_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bitmap_q   <= '0;
      sent_cnt_q <= '0;
      dup_q      <= '0;
      ovf_q      <= '0;
`ifdef FMPS_WRITE_LINK_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      cur_data_q <= cur_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bitmap_q   <= bitmap_d;
      sent_cnt_q <= sent_cnt_d;
      dup_q      <= dup_d;
      ovf_q      <= ovf_d;
`ifdef FMPS_WRITE_LINK_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  // NOTE: storage is not reset; the pointers reset, so stale entries are never read.
  always_ff @(posedge auroraClk) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {fmpsIndex, fmpsData};
  end

  assign TDATA        = tdata_q;
  assign TVALID       = tvalid_q;
  assign TLAST        = tlast_q;
  assign sentBitmap   = bitmap_q;
  assign sentCounter  = sent_cnt_q;
  assign dupDropCount = dup_q;
  assign ovfDropCount = ovf_q;
  assign busy         = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_fmps_write_link.sv
// Bench for fmps_write_link: scenario tasks with a queue-based packet model.
module tb_fmps_write_link;

`ifdef FMPS_WRITE_LINK_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, chan_up, fa_strobe, fmps_strobe, tready;
  logic [4:0]  fmps_index;
  logic [31:0] fmps_data;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy;
  logic [31:0] sent_bitmap;
  logic [5:0]  sent_counter;
  logic [15:0] dup_cnt, ovf_cnt;

  logic        s_strobe, s_tready;
  logic [4:0]  s_index;
  logic [31:0] s_data, s_tdata, s_bitmap;
  logic        s_tvalid, s_tlast, s_busy;
  logic [5:0]  s_counter;
  logic [15:0] s_dup, s_ovf;

  fmps_write_link dut (
    .auroraClk(clk), .auroraReset(rst), .auroraChannelUp(chan_up), .FAstrobe(fa_strobe),
    .fmpsStrobe(fmps_strobe), .fmpsIndex(fmps_index), .fmpsData(fmps_data),
    .TDATA(tdata), .TVALID(tvalid), .TLAST(tlast), .TREADY(tready),
    .sentBitmap(sent_bitmap), .sentCounter(sent_counter), .dupDropCount(dup_cnt),
    .ovfDropCount(ovf_cnt), .busy(busy));

  fmps_write_link #(.FIFO_AW(2)) dut_s (
    .auroraClk(clk), .auroraReset(rst), .auroraChannelUp(chan_up), .FAstrobe(fa_strobe),
    .fmpsStrobe(s_strobe), .fmpsIndex(s_index), .fmpsData(s_data),
    .TDATA(s_tdata), .TVALID(s_tvalid), .TLAST(s_tlast), .TREADY(s_tready),
    .sentBitmap(s_bitmap), .sentCounter(s_counter), .dupDropCount(s_dup),
    .ovfDropCount(s_ovf), .busy(s_busy));

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] bitmap_m;
  int          cnt_m, dup_m, ovf_m, seq_m;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  bit          stab_en = 1'b0;

  function automatic logic [31:0] hdr(input logic [4:0] idx, input int seq);
    logic [31:0] h;
    h = 32'hB6CF0000 | (32'(idx) << 10);
    if (SEQ_EN) h = h | 32'(seq % 1024);
    return h;
  endfunction

  function automatic void model_reset();
    bitmap_m = '0; cnt_m = 0; dup_m = 0; ovf_m = 0; seq_m = 0;
    exp_q.delete(); rx_q.delete();
  endfunction

  // Packet-level model of one submission (default DUT never fills its FIFO here).
  function automatic void model_submit(input logic [4:0] idx, input logic [31:0] data, input logic fa);
    if (fa) begin bitmap_m = '0; cnt_m = 0; end
    if (!chan_up) ovf_m++;
    else if (bitmap_m[idx]) dup_m++;
    else begin
      bitmap_m[idx] = 1'b1;
      exp_q.push_back({1'b0, hdr(idx, seq_m)});
      exp_q.push_back({1'b1, data});
      seq_m++;
      cnt_m++;
    end
  endfunction

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  initial begin : monitor
    logic        prev_stall;
    logic [33:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst && tvalid && tready) rx_q.push_back({tlast, tdata});
      if (stab_en && prev_stall) begin
        total_cnt++;
        if ({tdata, tvalid, tlast} !== prev_out)
          $display("FAIL t3_stall_hold: got %h required %h", {tdata, tvalid, tlast}, prev_out);
        else pass_cnt++;
      end
      prev_stall = tvalid && !tready;
      prev_out   = {tdata, tvalid, tlast};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic submit(input logic [4:0] idx, input logic [31:0] data, input logic with_fa);
    fmps_strobe = 1'b1; fmps_index = idx; fmps_data = data; fa_strobe = with_fa;
    model_submit(idx, data, with_fa);
    @(posedge clk); #1;
    fmps_strobe = 1'b0; fa_strobe = 1'b0;
  endtask

  task automatic fa_pulse();
    fa_strobe = 1'b1; bitmap_m = '0; cnt_m = 0;
    @(posedge clk); #1;
    fa_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || tvalid) && n < 500) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (busy || tvalid) $display("FAIL %s_drain: busy=%0b after %0d cycles, required 0", name, busy, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; chan_up = 1'b1; fa_strobe = 1'b0; fmps_strobe = 1'b0; tready = 1'b1;
    fmps_index = '0; fmps_data = '0;
    s_strobe = 1'b0; s_index = '0; s_data = '0; s_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({tvalid, tlast, busy} !== 3'b000) $display("FAIL rst_flags: got %b required 000", {tvalid, tlast, busy});
    else pass_cnt++;
    total_cnt++;
    if (tdata !== 32'h0) $display("FAIL rst_tdata: got %h required 0", tdata); else pass_cnt++;
    total_cnt++;
    if ({sent_bitmap, sent_counter, dup_cnt, ovf_cnt} !== '0)
      $display("FAIL rst_status: got %h/%0d/%0d/%0d required 0", sent_bitmap, sent_counter, dup_cnt, ovf_cnt);
    else pass_cnt++;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    total_cnt++;
    if (tvalid !== 1'b0) $display("FAIL rst_release_tvalid: got %b required 0", tvalid); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    rx_q.delete(); exp_q.delete();
    tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = {3'b000, 5'(i), 16'hCACA, 8'h01};
      submit(5'(i), d, 1'b0);
      repeat (15) begin @(posedge clk); #1; end
    end
    wait_idle("t1");
    total_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL t1_beats: got %0d required %0d", rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL t1_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sent_counter !== 6'(cnt_m)) $display("FAIL t1_counter: got %0d required %0d", sent_counter, cnt_m);
    else pass_cnt++;
    total_cnt++;
    if (sent_bitmap !== bitmap_m) $display("FAIL t1_bitmap: got %h required %h", sent_bitmap, bitmap_m);
    else pass_cnt++;
    total_cnt++;
    if ({dup_cnt, ovf_cnt} !== {16'(dup_m), 16'(ovf_m)})
      $display("FAIL t1_drops: got %0d/%0d required %0d/%0d", dup_cnt, ovf_cnt, dup_m, ovf_m);
    else pass_cnt++;
  endtask

  task automatic test_duplicate();
    fa_pulse();
    rx_q.delete(); exp_q.delete();
    submit(5'd3, $urandom, 1'b0);
    submit(5'd3, $urandom, 1'b0);
    wait_idle("t2a");
    total_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL t2_beats: got %0d required %0d", rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL t2_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (dup_cnt !== 16'(dup_m)) $display("FAIL t2_dup: got %0d required %0d", dup_cnt, dup_m); else pass_cnt++;
    total_cnt++;
    if (sent_counter !== 6'(cnt_m)) $display("FAIL t2_counter: got %0d required %0d", sent_counter, cnt_m);
    else pass_cnt++;
    // FA and resubmission of the same index in one cycle: accepted into the new cycle.
    rx_q.delete(); exp_q.delete();
    submit(5'd3, $urandom, 1'b1);
    total_cnt++;
    if (sent_bitmap !== bitmap_m) $display("FAIL t2_fa_bitmap: got %h required %h", sent_bitmap, bitmap_m);
    else pass_cnt++;
    wait_idle("t2b");
    total_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL t2_resend_beats: got %0d required %0d", rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL t2_resend_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (dup_cnt !== 16'(dup_m)) $display("FAIL t2_dup_after: got %0d required %0d", dup_cnt, dup_m); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] perm [32];
    logic [4:0] t;
    int j, sub;
    for (int i = 0; i < 32; i++) perm[i] = 5'(i);
    for (int i = 31; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    fa_pulse();
    rx_q.delete(); exp_q.delete();
    stab_en = 1'b1;
    sub = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tready = 1'($urandom_range(0, 1));
      if (sub < 12) begin
        fmps_strobe = 1'b1; fmps_index = perm[sub]; fmps_data = $urandom;
        model_submit(fmps_index, fmps_data, 1'b0);
        sub++;
      end else fmps_strobe = 1'b0;
      @(posedge clk); #1;
      if (sub == 12 && !busy && !tvalid) break;
    end
    fmps_strobe = 1'b0;
    tready = 1'b1;
    wait_idle("t3");
    stab_en = 1'b0;
    total_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL t3_beats: got %0d required %0d", rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL t3_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sent_counter !== 6'(cnt_m)) $display("FAIL t3_counter: got %0d required %0d", sent_counter, cnt_m);
    else pass_cnt++;
  endtask

  // Depth-4 instance with a stalled sink: 1 in flight + 4 queued, sixth dropped.
  task automatic test_fifo_full();
    s_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_strobe = 1'b1; s_index = 5'(i); s_data = $urandom;
      @(posedge clk); #1;
    end
    s_strobe = 1'b0;
    total_cnt++;
    if (s_ovf !== 16'd1) $display("FAIL t4_ovf: got %0d required 1", s_ovf); else pass_cnt++;
    total_cnt++;
    if (s_bitmap !== 32'h0000001F) $display("FAIL t4_bitmap: got %h required 0000001f", s_bitmap); else pass_cnt++;
    total_cnt++;
    if ({s_tvalid, s_busy, s_tdata} !== {2'b11, hdr(5'd0, 0)})
      $display("FAIL t4_head: got %b%b %h required 11 %h", s_tvalid, s_busy, s_tdata, hdr(5'd0, 0));
    else pass_cnt++;
    total_cnt++;
    if ({s_tlast, s_counter, s_dup} !== '0)
      $display("FAIL t4_idle_fields: got %b/%0d/%0d required 0", s_tlast, s_counter, s_dup);
    else pass_cnt++;
  endtask

  task automatic test_channel_down();
    fa_pulse();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) submit(5'(20 + i), $urandom, 1'b0);
    tready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({tvalid, tlast} !== 2'b11) $display("FAIL t5_in_dat: got %b required 11", {tvalid, tlast}); else pass_cnt++;
    tready = 1'b0;
    chan_up = 1'b0;
    @(posedge clk); #1;
    ovf_m += 3;  // three entries were still queued behind the abandoned packet
    seq_m = 0;
    total_cnt++;
    if ({tvalid, tlast, busy} !== 3'b000) $display("FAIL t5_abandon: got %b required 000", {tvalid, tlast, busy});
    else pass_cnt++;
    total_cnt++;
    if (ovf_cnt !== 16'(ovf_m)) $display("FAIL t5_flush_ovf: got %0d required %0d", ovf_cnt, ovf_m); else pass_cnt++;
    submit(5'd1, $urandom, 1'b0);
    submit(5'd2, $urandom, 1'b0);
    total_cnt++;
    if (ovf_cnt !== 16'(ovf_m)) $display("FAIL t5_down_ovf: got %0d required %0d", ovf_cnt, ovf_m); else pass_cnt++;
    total_cnt++;
    if (sent_bitmap !== bitmap_m) $display("FAIL t5_bitmap_kept: got %h required %h", sent_bitmap, bitmap_m);
    else pass_cnt++;
    chan_up = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    fa_pulse();
    tready = 1'b0;
    submit(5'd9, $urandom, 1'b0);
    @(posedge clk); #1;
    total_cnt++;
    if (tvalid !== 1'b1) $display("FAIL t6_pre_tvalid: got %b required 1", tvalid); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if ({tvalid, tlast, busy, tdata} !== '0)
      $display("FAIL t6_async_out: got %b%b%b %h required 000 0", tvalid, tlast, busy, tdata);
    else pass_cnt++;
    total_cnt++;
    if ({sent_bitmap, sent_counter, dup_cnt, ovf_cnt} !== '0)
      $display("FAIL t6_async_status: got %h/%0d/%0d/%0d required 0", sent_bitmap, sent_counter, dup_cnt, ovf_cnt);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tready = 1'b1;
    submit(5'd7, $urandom, 1'b0);
    wait_idle("t6");
    total_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL t6_beats: got %0d required %0d", rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL t6_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicate();
    test_back_to_back();
    test_fifo_full();
    test_channel_down();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fmps_write_link.md
Name: fmps_write_link

Overview:
- Transmit end of the FMPS Aurora link; the other end is the FMPS read link.
- Accepts per-FMPS status words from local fast-protection logic and queues them in a small FIFO.
- Serialises each queued word as a 2-beat AXI-Stream packet (header, data) on the Aurora TX user interface, running in the Aurora user clock domain.
- Enforces at most one packet per FMPS index per FA cycle, and reports drops and overflows.

Parameters:
- INDEX_WIDTH, 5: width of the FMPS index field; the bitmap has 1<<INDEX_WIDTH bits.
- FIFO_AW, 4: FIFO address width; depth is 1<<FIFO_AW entries of INDEX_WIDTH+32 bits.
- HEADER_MAGIC, 16'hB6CF: header word bits [31:16].

Ports:
- auroraClk  in  1: Aurora user clock; the only clock.
- auroraReset  in  1: asynchronous, active-high reset.
- auroraChannelUp  in  1: Aurora channel status.
- FAstrobe  in  1: one-cycle fast-acquisition cycle marker.
- fmpsStrobe  in  1: submit one status word.
- fmpsIndex  in  INDEX_WIDTH: FMPS index of the submitted word.
- fmpsData  in  32: payload word, sent verbatim.
- TDATA  out  32: AXI-Stream data.
- TVALID  out  1: AXI-Stream valid.
- TLAST  out  1: AXI-Stream last.
- TREADY  in  1: AXI-Stream ready.
- sentBitmap  out  1<<INDEX_WIDTH: indexes accepted in the current FA cycle.
- sentCounter  out  INDEX_WIDTH+1: number of packets fully sent in the current FA cycle.
- dupDropCount  out  16: saturating count of duplicate-index drops.
- ovfDropCount  out  16: saturating count of FIFO-full or channel-down drops.
- busy  out  1: FIFO non-empty or a packet in flight.

Behaviour:
- Reset (async assert, sync release):
  - TVALID=0, TLAST=0, TDATA=0.
  - FIFO empty; state IDLE.
  - sentBitmap=0, sentCounter=0, dupDropCount=0, ovfDropCount=0, busy=0.
- Packet format:
  - Header word: [31:16]=HEADER_MAGIC, [15]=0, [14:10]=index (INDEX_WIDTH bits starting at bit 10), [9:0]=0.
  - Data word: fmpsData.
  - TLAST=1 on the data beat only.
- Submit (fmpsStrobe=1), evaluated in priority order:
  - auroraChannelUp=0: drop, ovfDropCount+1.
  - sentBitmap[fmpsIndex]=1: drop, dupDropCount+1.
  - FIFO full: drop, ovfDropCount+1; bitmap unchanged.
  - Otherwise: write {index,data} into the FIFO; set sentBitmap[index] on the next edge.
- FAstrobe:
  - sentBitmap and sentCounter clear to 0 on the next edge.
  - FIFO contents and the in-flight packet are unaffected; they drain normally.
  - FAstrobe and fmpsStrobe in the same cycle: the submission belongs to the new cycle. The bitmap ends as only that index set; the duplicate check uses the cleared bitmap.
- State machine (IDLE, HDR, DAT):
  - IDLE: if FIFO non-empty and channel up, pop the FIFO and load the header into TDATA with TVALID=1, TLAST=0; go to HDR. First header beat appears 1 cycle after a write into an empty FIFO.
  - HDR: hold TDATA, TVALID and TLAST stable until TREADY. On TVALID&TREADY, load the data word with TLAST=1; go to DAT.
  - DAT: hold until TREADY. On handshake:
    - sentCounter+1, saturating at 1<<INDEX_WIDTH; the increment is suppressed if FAstrobe occurs in the same cycle.
    - If the FIFO is non-empty, load the next header directly (back-to-back, no idle beat); else TVALID=0 and go to IDLE.
  - Throughput: 2 cycles per packet when TREADY=1.
- Channel down mid-operation (auroraChannelUp falls):
  - The next edge forces TVALID=0, TLAST=0 and state IDLE; the in-flight packet is abandoned.
  - The FIFO is flushed; each flushed entry adds 1 to ovfDropCount (counted in one edge as the FIFO occupancy, saturating).
  - The bitmap is kept.
- Drop counters saturate at 16'hFFFF.
- FIFO write and read in the same cycle while full: the write is accepted, because the pop frees a slot.

Optional Feature:
- Macro: FMPS_WRITE_LINK_SEQ_EN.
- Defined: header [9:0] carries a 10-bit packet sequence number.
  - Increments after each completed DAT handshake and wraps 1023 -> 0.
  - Resets to 0 on auroraReset and on channel down.
- Undefined: header [9:0]=0 and no sequence register is synthesised.

Test Plan:
1. Channel up, TREADY=1; submit indexes 0..11 with fmpsData={3'b0,idx,16'hCACA,8'h01}, one per 16 cycles.
   - Required: 12 two-beat packets with header 0xB6CF0000 | (idx<<10), data echoed, TLAST on beat 2.
   - sentCounter=12; sentBitmap=0x00000FFF.
2. Submit index 3 twice in one FA cycle.
   - Required: one packet only; dupDropCount=1.
   - After FAstrobe, index 3 submitted again is sent.
3. TREADY random at 50%, 12 back-to-back submissions.
   - Required: TDATA/TVALID/TLAST never change while TVALID&!TREADY.
   - All 12 packets arrive in order.
4. FIFO_AW=2, TREADY=0, 6 submissions.
   - Required: 4 queued plus 1 in flight, leaving 1 dropped; ovfDropCount=1.
5. Drop auroraChannelUp during a DAT beat with 3 queued.
   - Required: TVALID=0 next cycle, busy=0, ovfDropCount=3.
   - Submissions while down are counted as drops.
6. Assert auroraReset asynchronously mid-packet.
   - Required: outputs go to reset values immediately (before the next edge); after release, a new submission produces a clean packet, and with FMPS_WRITE_LINK_SEQ_EN its sequence number is 0.
